mips_run_ctrl: RTL and testbench
================================

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter NB_CNT, default 32, width of executed-cycle counter.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, enabled cycles after halt detection needed to retire HALT and older instructions through EX/MEM/WB.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  request continuous execution.
REQ-006 SHALL have port step_i  input  1  request one pipeline advance.
REQ-007 SHALL have port pause_i  input  1  request stop of continuous execution.
REQ-008 SHALL have port clear_i  input  1  return from DONE or IDLE with counter cleared.
REQ-009 SHALL have port halt_detected_i  input  1  HALT opcode decoded in ID by the control unit.
REQ-010 SHALL have port pipe_en_o  output  1  global pipeline-register and datapath enable.
REQ-011 SHALL have port pc_en_o  output  1  PC update enable.
REQ-012 SHALL have port busy_o  output  1  high in RUN, STEP, DRAIN.
REQ-013 SHALL have port done_o  output  1  high in DONE.
REQ-014 SHALL have port state_o  output  3  encoded state.
REQ-015 SHALL have port cycle_count_o  output  NB_CNT  count of cycles with pipe_en_o=1.

Function
REQ-016 SHALL implement states IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4; codes 5-7 unreachable and SHALL go to IDLE next cycle.
REQ-017 SHALL decode outputs combinationally from state: pipe_en_o=1 in RUN/STEP/DRAIN, else 0; busy_o same as pipe_en_o; done_o=1 only in DONE.
REQ-018 SHALL drive pc_en_o=1 in RUN/STEP only when halt_detected_i=0; pc_en_o=0 in all other states and in any cycle with halt_detected_i=1.
REQ-019 IDLE: start_i -> RUN; else step_i -> STEP; else clear_i -> IDLE with cycle_count_o cleared; start_i wins over step_i.
REQ-020 RUN: halt_detected_i -> DRAIN; else pause_i -> IDLE; else stay; start_i/step_i/clear_i ignored.
REQ-021 STEP: lasts exactly one cycle; halt_detected_i -> DRAIN, else -> IDLE; pause_i ignored.
REQ-022 DRAIN: drain counter loaded with DRAIN_CYCLES on entry, decremented each DRAIN cycle; DRAIN lasts exactly DRAIN_CYCLES cycles then -> DONE; pause_i, start_i, step_i, halt_detected_i ignored.
REQ-023 DONE: stay until clear_i -> IDLE with cycle_count_o cleared; start_i/step_i ignored.
REQ-024 halt_detected_i and pause_i together in RUN SHALL go to DRAIN (halt wins).
REQ-025 cycle_count_o SHALL increment by 1 on each edge where pipe_en_o=1, saturate at 2^NB_CNT-1, and hold across IDLE pauses.
REQ-026 DRAIN_CYCLES=0 SHALL make halt detection go directly to DONE.

Reset
REQ-027 rst_n_i=0 SHALL immediately force IDLE, drain counter 0, cycle_count_o 0, all 1-bit outputs 0, state_o 0, regardless of clock or current state.
REQ-028 Release of rst_n_i SHALL take effect on the next rising edge; no input is acted on while rst_n_i=0.

Verification
REQ-029 Reset mid-DRAIN (DRAIN_CYCLES=3, 1 drain cycle done): assert rst_n_i between edges -> state_o=0, pipe_en_o=0, cycle_count_o=0 without waiting for an edge.
REQ-030 start_i pulse, halt_detected_i pulse in 6th RUN cycle -> pc_en_o=0 in that cycle, 3 DRAIN cycles, then done_o=1, cycle_count_o=9.
REQ-031 From IDLE, three step_i pulses spaced 2 cycles apart -> three single-cycle pipe_en_o pulses, state_o back to 0, cycle_count_o=3.
REQ-032 In RUN, pause_i and halt_detected_i same cycle -> state_o=3 next cycle; pause_i alone -> state_o=0, counter held.
REQ-033 clear_i in RUN -> ignored; clear_i in DONE -> state_o=0, done_o=0, cycle_count_o=0 next cycle.
REQ-034 NB_CNT=4, 20 RUN cycles then pause_i -> cycle_count_o=15 (saturated).

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run/step/drain sequencer for a pipelined MIPS core.
// Gates the pipeline and PC enables, retires the in-flight instructions
// after a HALT is decoded, and counts every cycle the pipeline advanced.
module mips_run_ctrl #(
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              pause_i,
    input  logic              clear_i,
    input  logic              halt_detected_i,
    output logic              pipe_en_o,
    output logic              pc_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        state_o,
    output logic [NB_CNT-1:0] cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0 or 1.
    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

    // With no drain window a decoded HALT completes immediately.
    localparam state_t HALT_TARGET = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;

    state_t              state_q;
    state_t              state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [NB_CNT-1:0]   cycle_cnt_q;
    logic                cnt_clear;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] val);
        if (&val) begin
            return val;
        end
        return val + NB_CNT'(1);
    endfunction

    // Next-state and output decode; illegal codes fall back to IDLE.
    always_comb begin
        state_d   = S_IDLE;
        cnt_clear = 1'b0;
        pipe_en_o = 1'b0;
        pc_en_o   = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end else if (step_i) begin
                    state_d = S_STEP;
                end else begin
                    state_d   = S_IDLE;
                    cnt_clear = clear_i;
                end
            end
            S_RUN: begin
                pipe_en_o = 1'b1;
                // Freeze the PC on the HALT so nothing younger enters the pipe.
                pc_en_o   = ~halt_detected_i;
                if (halt_detected_i) begin
                    state_d = HALT_TARGET;
                end else if (pause_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                pipe_en_o = 1'b1;
                pc_en_o   = ~halt_detected_i;
                state_d   = halt_detected_i ? HALT_TARGET : S_IDLE;
            end
            S_DRAIN: begin
                pipe_en_o = 1'b1;
                state_d   = (drain_cnt_q <= DRAIN_LAST) ? S_DONE : S_DRAIN;
            end
            S_DONE: begin
                done_o = 1'b1;
                if (clear_i) begin
                    state_d   = S_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o        = pipe_en_o;
    assign state_o       = state_q;
    assign cycle_count_o = cycle_cnt_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain counter: loaded on entry to DRAIN, counts down each DRAIN cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drain_cnt_q <= '0;
        end else if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) begin
            drain_cnt_q <= DRAIN_LOAD;
        end else if ((state_q == S_DRAIN) && (drain_cnt_q != '0)) begin
            drain_cnt_q <= drain_cnt_q - DRAIN_LAST;
        end
    end

    // Executed-cycle counter: advances with the pipeline enable, held while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q <= '0;
        end else if (cnt_clear) begin
            cycle_cnt_q <= '0;
        end else if (pipe_en_o) begin
            cycle_cnt_q <= sat_inc(cycle_cnt_q);
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a default instance and a small one (4-bit counter,
// no drain window) share the stimulus and are compared against a mode-level model.
module tb_mips_run_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_r = 1'b0, step_r = 1'b0, pause_r = 1'b0, clear_r = 1'b0, halt_r = 1'b0;

    logic        u0_pipe_en, u0_pc_en, u0_busy, u0_done;
    logic [2:0]  u0_state;
    logic [31:0] u0_cnt;
    logic        u1_pipe_en, u1_pc_en, u1_busy, u1_done;
    logic [2:0]  u1_state;
    logic [3:0]  u1_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per instance.
    int    m_state [2];
    int    m_drain [2];
    longint m_cnt  [2];
    longint m_max  [2];
    int    m_dc    [2];

    always #5 clk = ~clk;

    mips_run_ctrl #(.NB_CNT(32), .DRAIN_CYCLES(3)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r), .step_i(step_r),
        .pause_i(pause_r), .clear_i(clear_r), .halt_detected_i(halt_r),
        .pipe_en_o(u0_pipe_en), .pc_en_o(u0_pc_en), .busy_o(u0_busy),
        .done_o(u0_done), .state_o(u0_state), .cycle_count_o(u0_cnt)
    );

    mips_run_ctrl #(.NB_CNT(4), .DRAIN_CYCLES(0)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r), .step_i(step_r),
        .pause_i(pause_r), .clear_i(clear_r), .halt_detected_i(halt_r),
        .pipe_en_o(u1_pipe_en), .pc_en_o(u1_pc_en), .busy_o(u1_busy),
        .done_o(u1_done), .state_o(u1_state), .cycle_count_o(u1_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_drain[k] = 0;
            m_cnt[k]   = 0;
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        int s;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            s = m_state[k];
            if (s == 1 || s == 2 || s == 3)
                m_cnt[k] = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_max[k];
            case (s)
                0: begin
                    if (start_r) s = 1;
                    else if (step_r) s = 2;
                    else if (clear_r) m_cnt[k] = 0;
                end
                1, 2: begin
                    if (halt_r) begin
                        if (m_dc[k] == 0) s = 4;
                        else begin s = 3; m_drain[k] = m_dc[k]; end
                    end else if (s == 2 || pause_r) begin
                        s = 0;
                    end
                end
                3: begin
                    m_drain[k]--;
                    if (m_drain[k] == 0) s = 4;
                end
                default: begin
                    if (clear_r) begin s = 0; m_cnt[k] = 0; end
                end
            endcase
            m_state[k] = s;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] obs_st [2], obs_pe [2], obs_pc [2], obs_bz [2], obs_dn [2], obs_ct [2];
        logic        running, exec;
        obs_st[0] = 64'(u0_state);   obs_st[1] = 64'(u1_state);
        obs_pe[0] = 64'(u0_pipe_en); obs_pe[1] = 64'(u1_pipe_en);
        obs_pc[0] = 64'(u0_pc_en);   obs_pc[1] = 64'(u1_pc_en);
        obs_bz[0] = 64'(u0_busy);    obs_bz[1] = 64'(u1_busy);
        obs_dn[0] = 64'(u0_done);    obs_dn[1] = 64'(u1_done);
        obs_ct[0] = 64'(u0_cnt);     obs_ct[1] = 64'(u1_cnt);
        for (int k = 0; k < 2; k++) begin
            running = (m_state[k] >= 1 && m_state[k] <= 3);
            exec    = (m_state[k] == 1 || m_state[k] == 2) && !halt_r;
            chk($sformatf("%s/u%0d/state", tag, k), obs_st[k], 64'(m_state[k]));
            chk($sformatf("%s/u%0d/pipe_en", tag, k), obs_pe[k], 64'(running));
            chk($sformatf("%s/u%0d/pc_en", tag, k), obs_pc[k], 64'(exec));
            chk($sformatf("%s/u%0d/busy", tag, k), obs_bz[k], 64'(running));
            chk($sformatf("%s/u%0d/done", tag, k), obs_dn[k], 64'(m_state[k] == 4));
            chk($sformatf("%s/u%0d/count", tag, k), obs_ct[k], m_cnt[k]);
        end
    endtask

    task automatic set_in(input logic s, input logic st, input logic p, input logic c, input logic h);
        start_r = s; step_r = st; pause_r = p; clear_r = c; halt_r = h;
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic tick(input string tag, input logic s, input logic st, input logic p,
                        input logic c, input logic h);
        set_in(s, st, p, c, h);
        #1;
        check_outputs(tag);
        step_clk();
    endtask

    initial begin
        m_dc[0] = 3;  m_max[0] = 64'hFFFF_FFFF;
        m_dc[1] = 0;  m_max[1] = 15;
        model_reset();

        // Power-on reset, asserted asynchronously.
        #2 rst_n = 1'b0;
        #1;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Three single-cycle steps, two cycles apart.
        for (int i = 0; i < 3; i++) begin
            tick("step_pulse", 0, 1, 0, 0, 0);
            tick("step_gap", 0, 0, 0, 0, 0);
            tick("step_gap", 0, 0, 0, 0, 0);
        end
        chk("steps/state", 64'(u0_state), 0);
        chk("steps/count", 64'(u0_cnt), 3);

        // Clear from IDLE.
        tick("idle_clear", 0, 0, 0, 1, 0);
        chk("idle_clear/count", 64'(u0_cnt), 0);

        // Run, HALT in the 6th RUN cycle, drain, done.
        tick("run_start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick("run", 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 1);
        #1;
        check_outputs("run_halt");
        chk("run_halt/pc_en", 64'(u0_pc_en), 0);
        chk("run_halt/pipe_en", 64'(u0_pipe_en), 1);
        step_clk();
        chk("halt_nodrain/u1_state", 64'(u1_state), 4);
        chk("halt_nodrain/u1_count", 64'(u1_cnt), 6);
        for (int i = 0; i < 3; i++) begin
            chk("drain/state", 64'(u0_state), 3);
            tick("drain", i[0], ~i[0], 1, 0, 1);
        end
        chk("done/done", 64'(u0_done), 1);
        chk("done/count", 64'(u0_cnt), 9);
        tick("done_hold", 1, 1, 0, 0, 0);
        chk("done_hold/state", 64'(u0_state), 4);

        // Clear in DONE returns to IDLE with the counter zeroed.
        tick("done_clear", 0, 0, 0, 1, 0);
        chk("done_clear/state", 64'(u0_state), 0);
        chk("done_clear/done", 64'(u0_done), 0);
        chk("done_clear/count", 64'(u0_cnt), 0);

        // Clear while running is ignored; pause alone returns to IDLE and holds the count.
        tick("run2_start", 1, 0, 0, 0, 0);
        tick("run2_clear", 0, 0, 0, 1, 0);
        chk("run_clear/state", 64'(u0_state), 1);
        chk("run_clear/count", 64'(u0_cnt), 1);
        tick("run2_pause", 0, 0, 1, 0, 0);
        tick("idle_wait", 0, 0, 0, 0, 0);
        chk("pause/state", 64'(u0_state), 0);
        chk("pause/count", 64'(u0_cnt), 2);

        // Pause together with HALT: HALT wins.
        tick("run3_start", 1, 0, 0, 0, 0);
        tick("run3_pause_halt", 0, 0, 1, 0, 1);
        chk("pause_halt/state", 64'(u0_state), 3);
        for (int i = 0; i < 3; i++) tick("drain2", 0, 0, 0, 0, 0);
        tick("done2_clear", 0, 0, 0, 1, 0);

        // 20 RUN cycles: the 4-bit counter saturates at 15.
        tick("sat_start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) tick("sat_run", 0, 0, 0, 0, 0);
        tick("sat_pause", 0, 0, 1, 0, 0);
        chk("sat/u1_count", 64'(u1_cnt), 15);
        chk("sat/u0_count", 64'(u0_cnt), 20);
        chk("sat/state", 64'(u0_state), 0);

        // Reset between edges after one DRAIN cycle.
        tick("rst_start", 1, 0, 0, 0, 0);
        tick("rst_halt", 0, 0, 0, 0, 1);
        tick("rst_drain1", 0, 0, 0, 0, 0);
        chk("pre_rst/state", 64'(u0_state), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst/state", 64'(u0_state), 0);
        chk("mid_rst/pipe_en", 64'(u0_pipe_en), 0);
        chk("mid_rst/count", 64'(u0_cnt), 0);
        model_reset();
        check_outputs("mid_rst");

        // Inputs are not acted on while reset is held.
        set_in(1, 1, 0, 0, 1);
        step_clk();
        check_outputs("rst_hold");
        chk("rst_hold/state", 64'(u0_state), 0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick("rand",
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
